// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the RAM arbiter
// Purpose: word and RAM-state types, arbiter FSM state, channel offsets.
// Contents:
//   word_t        32-bit data/address word
//   ramstate_t    FREE/BUSY/ACCESS/ERROR as reported by the RAM
//   arb_state_t   IDLE/GRANT arbiter states
//   ARB_CH_DCACHE channel offset of a core's dcache (channel 2c)
//   ARB_CH_ICACHE channel offset of a core's icache (channel 2c+1)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_CH_DCACHE = 0;
  localparam int ARB_CH_ICACHE = 1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin request picker
// Purpose: selects the first set request at or after ptr, wrapping modulo N.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  starting position of the search
//   valid out 1   at least one request is set
//   idx   out IW  index of the selected request (0 when valid=0)
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int c;

  // Walk from the farthest offset down to ptr itself so the nearest
  // requester at or after ptr is the last assignment and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % N;
      if (req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter of CPUS icache/dcache pairs onto one RAM
// Purpose: grants one channel at a time (channel 2c = dcache c, 2c+1 = icache c),
//   holds the grant until the RAM reports ACCESS or ERROR, then releases it.
// Optional feature: MEM_ARB_PERF_EN adds grant_cnt, one 32-bit completion
//   counter per channel.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   iREN/iaddr            icache read request and address per core
//   dREN/dWEN/daddr/dstore dcache read/write request, address, write data per core
//   iwait/dwait           per-core stalls, 0 only for the owner in its completion cycle
//   iload/dload           ramload broadcast to every cache
//   ramREN/ramWEN/ramaddr/ramstore  RAM request from the current owner
//   ramload/ramstate      RAM read data and status
//   grant_cnt             (MEM_ARB_PERF_EN only) per-channel completion counters
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  ramstate_t              ramstate
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [2*CPUS*32-1:0]   grant_cnt
`endif
);

  localparam int CH = 2 * CPUS;
  localparam int IW = $clog2(CH);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH-1:0] req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          complete;

  always_comb begin
    req = '0;
    for (int c = 0; c < CPUS; c++) begin
      req[2*c + ARB_CH_DCACHE] = dREN[c] | dWEN[c];
      req[2*c + ARB_CH_ICACHE] = iREN[c];
    end
  end

  rr_picker #(.N(CH), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A grant only completes while the owner still requests; a dropped
  // request is an abort and must not count or release a wait.
  assign complete = !RST && (state_q == GRANT) && req[owner_q] &&
                    ((ramstate == ACCESS) || (ramstate == ERROR));

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else begin
          for (int c = 0; c < CPUS; c++) begin
            if (owner_q == IW'(2*c + ARB_CH_DCACHE)) begin
              // Read and write together is illegal; the write is honoured.
              ramWEN   = dWEN[c];
              ramREN   = dREN[c] & ~dWEN[c];
              ramaddr  = daddr[c*WORD_W +: WORD_W];
              ramstore = dstore[c*WORD_W +: WORD_W];
              if (complete) dwait[c] = 1'b0;
            end
            if (owner_q == IW'(2*c + ARB_CH_ICACHE)) begin
              ramREN  = iREN[c];
              ramaddr = iaddr[c*WORD_W +: WORD_W];
              if (complete) iwait[c] = 1'b0;
            end
          end
          if (complete) begin
            rr_ptr_d = (owner_q == IW'(CH - 1)) ? '0 : owner_q + IW'(1);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons whatever access is in flight this very cycle.
    if (RST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] cnt_q [CH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else if (complete) begin
      cnt_q[owner_q] <= cnt_q[owner_q] + 32'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < CH; i++) grant_cnt[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - table-driven bench for memory_arbiter (CPUS=2)
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
`ifdef MEM_ARB_PERF_EN
  logic [127:0] grant_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_PERF_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic [1:0]  iren, dren, dwen;
    ramstate_t   rs;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic        chk_bus;
    logic [1:0]  iw, dw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                              ramstate_t rs, logic ren, logic wen, logic [31:0] addr,
                              logic [31:0] store, logic chk_bus, logic [1:0] iw, logic [1:0] dw);
    vec_t v;
    v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
    v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.chk_bus = chk_bus;
    v.iw = iw; v.dw = dw;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    else n_pass++;
  endtask

  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'h12345678;

  initial begin
    // channel addresses: d0=0x80, i0=0x100, d1=0x90, i1=0x40
    iaddr  = {32'h0000_0040, 32'h0000_0100};
    daddr  = {32'h0000_0090, 32'h0000_0080};
    dstore = {D1, D0};
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; ramload = '0; ramstate = FREE;

    // reset with every request high
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, ACCESS, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, ACCESS, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    // round robin 0,1,2,3,0 with an idle cycle between grants
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, FREE,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 1, 0, 32'h80, D0, 1, 2'b11, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 1, 0, 32'h100, 0, 1, 2'b10, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 1, 0, 32'h90, D1, 1, 2'b11, 2'b01));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 1, 0, 32'h40, 0, 1, 2'b01, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 1, 0, 32'h80, D0, 1, 2'b11, 2'b10));
    // single read by core1 icache, one FREE cycle then ACCESS
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, FREE,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, FREE,   1, 0, 32'h40, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40, 0, 1, 2'b01, 2'b11));
    // d0 write stretched by three BUSY cycles
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, BUSY,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, BUSY,   0, 1, 32'h80, D0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, BUSY,   0, 1, 32'h80, D0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, BUSY,   0, 1, 32'h80, D0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, ACCESS, 0, 1, 32'h80, D0, 1, 2'b11, 2'b10));
    // d1 read aborted mid-BUSY; pointer stays at 1 so i0 wins next
    vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, BUSY,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, BUSY,   1, 0, 32'h90, D1, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, BUSY,   0, 0, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b01, BUSY,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b01, ACCESS, 1, 0, 32'h100, 0, 1, 2'b10, 2'b11));
    // reset while d1 holds the grant, then d0 read+write -> write wins
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b01, BUSY,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b01, BUSY,   0, 0, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b01, BUSY,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b01, ACCESS, 0, 1, 32'h80, D0, 1, 2'b11, 2'b10));
    // ERROR completes like ACCESS
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, FREE,   0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, ERROR,  1, 0, 32'h100, 0, 1, 2'b10, 2'b11));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 0, 0, 1, 2'b11, 2'b11));

    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst; iREN = vecs[i].iren; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
      ramstate = vecs[i].rs;
      ramload = 32'hA500_0000 | 32'(i);
      @(negedge CLK);
      check("ramREN", i, 64'(ramREN), 64'(vecs[i].ren));
      check("ramWEN", i, 64'(ramWEN), 64'(vecs[i].wen));
      check("iwait",  i, 64'(iwait),  64'(vecs[i].iw));
      check("dwait",  i, 64'(dwait),  64'(vecs[i].dw));
      if (vecs[i].chk_bus) begin
        check("ramaddr",  i, 64'(ramaddr),  64'(vecs[i].addr));
        check("ramstore", i, 64'(ramstore), 64'(vecs[i].store));
      end
      check("iload", i, iload, {2{32'hA500_0000 | 32'(i)}});
      check("dload", i, dload, {2{32'hA500_0000 | 32'(i)}});
      @(posedge CLK); #1;
    end

`ifdef MEM_ARB_PERF_EN
    // five completions on ch2 (d1) from a fresh reset
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dREN = 2'b10; ramstate = FREE;
      @(posedge CLK); #1;
      ramstate = ACCESS;
      @(posedge CLK); #1;
    end
    dREN = '0; ramstate = FREE;
    @(negedge CLK);
    check("grant_cnt2", 0, 64'(grant_cnt[64 +: 32]), 64'd5);
    check("grant_cnt0", 0, 64'(grant_cnt[0 +: 32]), 64'd0);
    check("grant_cnt3", 0, 64'(grant_cnt[96 +: 32]), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
